pll: RTL and testbench

PLL -- requirements
Module: pll

---
 rtl/pll.sv | 144 ++++++++++++++
 tb/tb_pll.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll.sv
// Behavioural clock synthesizer: measures the reference period and regenerates
// clk_o = clk_ref_i * F / R from an absolute phase accumulator (simulation only).
module pll #(
    parameter int REF_DEV_WIDTH = 8,
    parameter int FB_DIV_WIDTH  = 12
) (
    input  logic                     clk_ref_i,
    input  logic                     arst_ni,
    input  logic [REF_DEV_WIDTH-1:0] ref_div_i,
    input  logic [FB_DIV_WIDTH-1:0]  fb_div_i,
    output logic                     clk_o,
    output logic                     locked_o
);
    timeunit 1ns;
    timeprecision 1fs;

    localparam real         TREF_TOL   = 0.001;
    localparam int unsigned LOCK_EDGES = 4;

    logic                     r_gen;
    logic                     r_locked;
    logic                     r_clk_prev;
    logic                     r_cfg_dirty;
    logic                     r_have_edge;
    logic                     r_have_tref;
    logic [REF_DEV_WIDTH-1:0] r_ref_q;
    logic [FB_DIV_WIDTH-1:0]  r_fb_q;
    realtime                  r_last_edge;
    realtime                  r_tref;
    realtime                  r_half;
    int unsigned              r_lock_cnt;
    int unsigned              r_gen_epoch;
    int unsigned              r_edge_id;

    assign clk_o    = r_gen;
    assign locked_o = r_locked;

    // Bumping the epoch retires any edge generator still sleeping on a delay.
    task automatic stop_output();
        r_locked    = 1'b0;
        r_gen       = 1'b0;
        r_gen_epoch = r_gen_epoch + 1;
    endtask

    // Edge k lands at t0 + k*half, so delay rounding never accumulates.
    task automatic run_gen(input int unsigned epoch, input realtime t0, input realtime half);
        longint unsigned k;
        realtime         t_next;
        k = 1;
        while (epoch == r_gen_epoch) begin
            t_next = t0 + real'(k) * half;
            #(t_next - $realtime);
            if (epoch == r_gen_epoch && r_locked) begin
                r_gen = ~r_gen;
            end
            k = k + 1;
        end
    endtask

    task automatic watchdog(input int unsigned id, input realtime limit);
        #(limit);
        if (id == r_edge_id) begin
            stop_output();
            r_lock_cnt  = 0;
            r_have_edge = 1'b0;
            r_have_tref = 1'b0;
        end
    endtask

    task automatic ref_edge();
        realtime w_now;
        realtime w_tnew;
        realtime w_diff;
        logic    w_qual;
        w_now  = $realtime;
        w_qual = 1'b0;
        if (r_have_edge) begin
            w_tnew = w_now - r_last_edge;
            w_diff = (w_tnew > r_tref) ? (w_tnew - r_tref) : (r_tref - w_tnew);
            w_qual = r_have_tref && !r_cfg_dirty && (r_ref_q != '0) && (r_fb_q != '0)
                     && (w_diff <= TREF_TOL * r_tref);
            r_tref      = w_tnew;
            r_have_tref = 1'b1;
        end
        r_have_edge = 1'b1;
        r_last_edge = w_now;
        r_cfg_dirty = 1'b0;
        r_edge_id   = r_edge_id + 1;
        if (r_have_tref) begin
            fork
                automatic int unsigned w_id  = r_edge_id;
                automatic realtime     w_lim = 2.0 * r_tref;
                watchdog(w_id, w_lim);
            join_none
        end
        if (!w_qual) begin
            stop_output();
            r_lock_cnt = 0;
        end else if (!r_locked) begin
            r_lock_cnt = r_lock_cnt + 1;
            if (r_lock_cnt >= LOCK_EDGES) begin
                r_half      = r_tref * real'(r_ref_q) / real'(r_fb_q) / 2.0;
                r_gen_epoch = r_gen_epoch + 1;
                r_gen       = 1'b1;
                r_locked    = 1'b1;
                fork
                    automatic int unsigned w_ep   = r_gen_epoch;
                    automatic realtime     w_t0   = w_now;
                    automatic realtime     w_hlf  = r_half;
                    run_gen(w_ep, w_t0, w_hlf);
                join_none
            end
        end
    endtask

    // Reset, divider changes and reference edges all act in the timestep they occur.
    always begin : p_ctrl
        @(clk_ref_i or arst_ni or ref_div_i or fb_div_i);
        if (arst_ni !== 1'b1) begin
            stop_output();
            r_edge_id   = r_edge_id + 1;
            r_lock_cnt  = 0;
            r_have_edge = 1'b0;
            r_have_tref = 1'b0;
            r_tref      = 0.0;
            r_cfg_dirty = 1'b1;
            r_ref_q     = ref_div_i;
            r_fb_q      = fb_div_i;
        end else begin
            if (ref_div_i !== r_ref_q || fb_div_i !== r_fb_q) begin
                stop_output();
                r_lock_cnt  = 0;
                r_cfg_dirty = 1'b1;
                r_ref_q     = ref_div_i;
                r_fb_q      = fb_div_i;
            end
            if (clk_ref_i === 1'b1 && r_clk_prev !== 1'b1) begin
                ref_edge();
            end
        end
        r_clk_prev = clk_ref_i;
    end

endmodule

// File: tb/tb_pll.sv
// Bench for pll: directed vector table, reference/reset corner sequences and
// random divider configurations, each checked against a period scoreboard.
module tb_pll;
    timeunit 1ns;
    timeprecision 1fs;

    typedef struct {
        int      r;
        int      f;
        int      ncyc;
        realtime period;
    } vec_t;

    typedef struct {
        int      r;
        int      f;
        realtime period;
    } exp_t;

    logic        clk_ref = 1'b0;
    logic        arst_n;
    logic [7:0]  ref_div;
    logic [11:0] fb_div;
    logic        clk_o;
    logic        locked;

    realtime ref_half = 5.0;
    bit      ref_run  = 1'b1;

    int errors = 0;
    int checks = 0;

    exp_t sb[$];

    longint  clk_cnt    = 0;
    longint  tgt_a      = -1;
    longint  tgt_b      = -1;
    realtime t_a        = 0.0;
    realtime t_b        = 0.0;
    realtime t_clk_rise = 0.0;
    realtime t_lock     = 0.0;
    realtime t_unlock   = 0.0;
    int      lock_rises = 0;
    int      unlocks    = 0;

    pll #(.REF_DEV_WIDTH(8), .FB_DIV_WIDTH(12)) dut (
        .clk_ref_i (clk_ref),
        .arst_ni   (arst_n),
        .ref_div_i (ref_div),
        .fb_div_i  (fb_div),
        .clk_o     (clk_o),
        .locked_o  (locked)
    );

    always begin
        #(ref_half);
        if (ref_run) clk_ref = ~clk_ref;
    end

    always @(posedge clk_o) begin
        clk_cnt    = clk_cnt + 1;
        t_clk_rise = $realtime;
        if (clk_cnt == tgt_a) t_a = $realtime;
        if (clk_cnt == tgt_b) t_b = $realtime;
    end

    always @(posedge locked) begin
        lock_rises = lock_rises + 1;
        t_lock     = $realtime;
    end

    always @(negedge locked) begin
        unlocks  = unlocks + 1;
        t_unlock = $realtime;
    end

    task automatic check(input string name, input bit ok, input string detail);
        checks = checks + 1;
        if (!ok) begin
            errors = errors + 1;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    task automatic wait_lock(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk_ref);
            ok = (locked === 1'b1);
        end
    endtask

    task automatic apply_cfg(input int r, input int f, input realtime exp_p);
        bit      was_locked;
        bit      changed;
        realtime t_chg;
        was_locked = (locked === 1'b1);
        changed    = (ref_div != r[7:0]) || (fb_div != f[11:0]);
        t_chg      = $realtime;
        ref_div    = r[7:0];
        fb_div     = f[11:0];
        sb.push_back(exp_t'{r, f, exp_p});
        #1ps;
        if (was_locked && changed) begin
            check($sformatf("unlock_same_step R=%0d F=%0d", r, f),
                  (t_unlock == t_chg) && (locked === 1'b0) && (clk_o === 1'b0),
                  $sformatf("unlock at %0.6f ns locked=%b clk=%b, want unlock at %0.6f ns, both 0",
                            t_unlock, locked, clk_o, t_chg));
        end
    endtask

    task automatic measure(input int n, input real tol);
        exp_t    e;
        bit      ok;
        realtime avg;
        realtime dev;
        realtime t_end;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 1'b0, "got no expected entry, want one");
            return;
        end
        e = sb.pop_front();
        wait_lock(20, ok);
        check($sformatf("lock R=%0d F=%0d", e.r, e.f), ok,
              $sformatf("locked=%b after 20 ref cycles, want 1", locked));
        if (ok) begin
            tgt_a = clk_cnt + 2;
            tgt_b = tgt_a + n;
            t_end = $realtime + real'(n + 3) * e.period * 1.5 + 300.0;
            while (clk_cnt < tgt_b && $realtime < t_end) #1;
            check($sformatf("clk_running R=%0d F=%0d", e.r, e.f), clk_cnt >= tgt_b,
                  $sformatf("edges=%0d want >= %0d before timeout", clk_cnt, tgt_b));
            if (clk_cnt >= tgt_b) begin
                avg = (t_b - t_a) / real'(n);
                dev = (avg > e.period) ? (avg - e.period) / e.period : (e.period - avg) / e.period;
                check($sformatf("period R=%0d F=%0d", e.r, e.f), dev < tol,
                      $sformatf("avg %0.6f ns want %0.6f ns (rel dev %0.6f, limit %0.4f)",
                                avg, e.period, dev, tol));
            end
            tgt_a = -1;
            tgt_b = -1;
        end
    endtask

    initial begin
        vec_t   vecs[6];
        longint cc;
        int     lr;
        int     un;
        int     r;
        int     f;
        int     lo;
        int     hi;
        int     n;
        real    p;
        bit     ok;

        vecs = '{'{1, 1, 10000, 10.0}, '{1, 100, 10000, 0.1}, '{100, 1, 10, 1000.0},
                 '{3, 7, 2000, 30.0 / 7.0}, '{7, 3, 500, 70.0 / 3.0}, '{4, 9, 1000, 40.0 / 9.0}};

        arst_n  = 1'b0;
        ref_div = 8'd1;
        fb_div  = 12'd1;
        #50;
        check("reset_outputs", clk_o === 1'b0 && locked === 1'b0,
              $sformatf("clk=%b locked=%b want 0 0", clk_o, locked));
        #52;
        arst_n = 1'b1;
        repeat (3) @(posedge clk_ref);
        @(negedge clk_ref);
        check("no_early_lock", locked === 1'b0, $sformatf("locked=%b after 3 edges want 0", locked));
        repeat (3) @(posedge clk_ref);
        @(negedge clk_ref);
        check("lock_within_6", locked === 1'b1, $sformatf("locked=%b after 6 edges want 1", locked));
        check("clk_starts_with_lock", t_clk_rise == t_lock,
              $sformatf("first clk rise %0.6f ns want %0.6f ns", t_clk_rise, t_lock));

        foreach (vecs[i]) begin
            @(negedge clk_ref);
            #2;
            apply_cfg(vecs[i].r, vecs[i].f, vecs[i].period);
            measure(vecs[i].ncyc, 0.001);
        end

        @(negedge clk_ref);
        #2;
        lr      = lock_rises;
        cc      = clk_cnt;
        ref_div = 8'd0;
        fb_div  = 12'd3;
        #1000;
        check("r_zero_static", clk_cnt == cc && lock_rises == lr && clk_o === 1'b0 && locked === 1'b0,
              $sformatf("edges=%0d locks=%0d clk=%b locked=%b want %0d %0d 0 0",
                        clk_cnt, lock_rises, clk_o, locked, cc, lr));
        ref_div = 8'd5;
        fb_div  = 12'd0;
        #1000;
        check("f_zero_static", clk_cnt == cc && lock_rises == lr && clk_o === 1'b0 && locked === 1'b0,
              $sformatf("edges=%0d locks=%0d clk=%b locked=%b want %0d %0d 0 0",
                        clk_cnt, lock_rises, clk_o, locked, cc, lr));
        apply_cfg(5, 2, 25.0);
        measure(1000, 0.001);

        // Reference slows to 10.5 ns: the first stretched interval must drop lock.
        @(negedge clk_ref);
        #2;
        un       = unlocks;
        ref_half = 5.25;
        sb.push_back(exp_t'{5, 2, 26.25});
        @(posedge clk_ref);
        @(posedge clk_ref);
        @(negedge clk_ref);
        check("tref_step_unlock", locked === 1'b0 && unlocks == un + 1,
              $sformatf("locked=%b unlocks=%0d want 0 %0d", locked, unlocks, un + 1));
        measure(500, 0.001);

        @(negedge clk_ref);
        ref_run = 1'b0;
        #30;
        cc = clk_cnt;
        #10;
        check("ref_stop", locked === 1'b0 && clk_o === 1'b0 && clk_cnt == cc,
              $sformatf("locked=%b clk=%b edges=%0d want 0 0 %0d", locked, clk_o, clk_cnt, cc));
        ref_half = 5.0;
        ref_run  = 1'b1;
        sb.push_back(exp_t'{5, 2, 25.0});
        measure(200, 0.001);

        @(negedge clk_ref);
        #2;
        arst_n = 1'b0;
        #1ps;
        check("reset_immediate", locked === 1'b0 && clk_o === 1'b0,
              $sformatf("locked=%b clk=%b want 0 0", locked, clk_o));
        cc = clk_cnt;
        #200;
        check("reset_hold", clk_cnt == cc && locked === 1'b0 && clk_o === 1'b0,
              $sformatf("edges=%0d locked=%b clk=%b want %0d 0 0", clk_cnt, locked, clk_o, cc));
        arst_n = 1'b1;
        repeat (3) @(posedge clk_ref);
        @(negedge clk_ref);
        check("reset_requalify", locked === 1'b0, $sformatf("locked=%b after 3 edges want 0", locked));
        sb.push_back(exp_t'{5, 2, 25.0});
        measure(200, 0.001);

        for (int k = 0; k < 100; k++) begin
            r  = int'($urandom_range(255, 1));
            lo = (r + 99) / 100;
            hi = (r * 100 > 4095) ? 4095 : r * 100;
            f  = int'($urandom_range(hi, lo));
            p  = 10.0 * real'(r) / real'(f);
            n  = int'(500.0 / p);
            if (n < 2) n = 2;
            if (n > 1000) n = 1000;
            @(negedge clk_ref);
            #2;
            apply_cfg(r, f, p);
            measure(n, 0.01);
        end

        ok = (sb.size() == 0);
        check("scoreboard_drained", ok, $sformatf("%0d entries left want 0", sb.size()));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
